// File: rtl/motion_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : motion_scheduler
// Purpose  : Motion command sequencer between the command sources (decoded
//            speech/Bluetooth codes, IR line-follow) and the motor driver.
//            It accepts one command at a time over a valid/ready handshake.
//            It runs timed maneuvers (turn, U-turn, rotate) with cycle-exact
//            duration counters. An ultrasonic obstacle freezes the maneuver
//            and backs away, and the motor mode bus is driven every cycle.
// Ports    : clk, rst       - clock, asynchronous active-high reset
//            cmd_valid/cmd_code/cmd_ready - command handshake
//                             (0 STOP, 1 FWD, 2 BACK, 3 TURN_L, 4 TURN_R,
//                              5 UTURN, 6 ROT_L, 7 ROT_R)
//            abort          - synchronous kill of any activity
//            follow_en, ir_l, ir_r - IR target-follow controls (idle only)
//            distance       - ultrasonic distance in cm
//            mode           - motor command (000 stop, 001 right, 010 left,
//                             011 forward, 100 backward), registered
//            busy, done, state - status (registered)
// Revision : 1.0 - initial release
// ============================================================================
module motion_scheduler #(
  parameter int unsigned TURN_CYC  = 2**26,
  parameter int unsigned UTURN_CYC = 2**27,
  parameter int unsigned ROT_CYC   = 2**28,
  parameter int unsigned SAFE_DIST = 20,
  parameter int          DIST_W    = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [2:0]        cmd_code,
  output logic              cmd_ready,
  input  logic              abort,
  input  logic              follow_en,
  input  logic              ir_l,
  input  logic              ir_r,
  input  logic [DIST_W-1:0] distance,
  output logic [2:0]        mode,
  output logic              busy,
  output logic              done,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN_F  = 3'd1,
    S_RUN_B  = 3'd2,
    S_TURN   = 3'd3,
    S_POST_F = 3'd4,
    S_ROTATE = 3'd5
  } state_t;

  localparam logic [2:0] M_STOP  = 3'b000;
  localparam logic [2:0] M_RIGHT = 3'b001;
  localparam logic [2:0] M_LEFT  = 3'b010;
  localparam logic [2:0] M_FWD   = 3'b011;
  localparam logic [2:0] M_BACK  = 3'b100;

  localparam logic [31:0] TURN_LIM  = 32'(TURN_CYC);
  localparam logic [31:0] UTURN_LIM = 32'(UTURN_CYC);
  localparam logic [31:0] ROT_LIM   = 32'(ROT_CYC);

  localparam logic [DIST_W-1:0] SAFE_D   = DIST_W'(SAFE_DIST);
  localparam logic [DIST_W-1:0] NEAR_MIN = DIST_W'(15);
  localparam logic [DIST_W-1:0] NEAR_MAX = DIST_W'(60);

  state_t      cur_state, nxt_state;
  logic [31:0] cnt, nxt_cnt;
  logic [31:0] limit, nxt_limit;
  logic        dir_left, nxt_left;
  logic [2:0]  mode_r, nxt_mode;
  logic        done_r, nxt_done;
  logic        busy_r;

  logic obst, near, timed, accept, finish;

  assign obst   = (distance < SAFE_D);
  assign near   = (distance > NEAR_MIN) && (distance < NEAR_MAX);
  assign timed  = (cur_state == S_TURN) || (cur_state == S_ROTATE);
  // Timed maneuvers cannot be interrupted by a new command, and abort
  // always wins over a pending handshake in the same cycle.
  assign cmd_ready = !abort && !timed;
  assign accept    = cmd_valid && cmd_ready;
  // Completion is only allowed on an obstacle-free cycle, so an obstacle on
  // the final count cycle defers it.
  assign finish    = timed && !obst && (cnt == limit - 32'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= S_IDLE;
      cnt       <= 32'd0;
      limit     <= 32'd0;
      dir_left  <= 1'b0;
      mode_r    <= M_STOP;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      cnt       <= nxt_cnt;
      limit     <= nxt_limit;
      dir_left  <= nxt_left;
      mode_r    <= nxt_mode;
      done_r    <= nxt_done;
      busy_r    <= (nxt_state != S_IDLE);
    end
  end

  always_comb begin
    nxt_state = cur_state;
    nxt_cnt   = cnt;
    nxt_limit = limit;
    nxt_left  = dir_left;
    nxt_done  = 1'b0;
    nxt_mode  = M_STOP;

    if (abort) begin
      nxt_state = S_IDLE;
      nxt_cnt   = 32'd0;
    end else if (accept) begin
      // Any accepted command restarts the counter, even when it re-enters
      // the current state.
      nxt_cnt = 32'd0;
      case (cmd_code)
        3'd0: nxt_state = S_IDLE;
        3'd1: nxt_state = S_RUN_F;
        3'd2: nxt_state = S_RUN_B;
        3'd3: begin nxt_state = S_TURN;   nxt_left = 1'b1; nxt_limit = TURN_LIM;  end
        3'd4: begin nxt_state = S_TURN;   nxt_left = 1'b0; nxt_limit = TURN_LIM;  end
        3'd5: begin nxt_state = S_TURN;   nxt_left = 1'b1; nxt_limit = UTURN_LIM; end
        3'd6: begin nxt_state = S_ROTATE; nxt_left = 1'b1; nxt_limit = ROT_LIM;   end
        3'd7: begin nxt_state = S_ROTATE; nxt_left = 1'b0; nxt_limit = ROT_LIM;   end
        default: nxt_state = S_IDLE;
      endcase
    end else if (finish) begin
      nxt_done  = 1'b1;
      nxt_cnt   = 32'd0;
      nxt_state = (cur_state == S_TURN) ? S_POST_F : S_IDLE;
    end else if (timed && !obst) begin
      nxt_cnt = cnt + 32'd1;
    end

    // The mode register always describes the state being entered, evaluated
    // with this cycle's sensor inputs (so sensors act one edge later).
    case (nxt_state)
      S_RUN_F, S_POST_F: nxt_mode = obst ? M_STOP : M_FWD;
      S_RUN_B:           nxt_mode = M_BACK;
      S_TURN, S_ROTATE:  nxt_mode = obst ? M_BACK : (nxt_left ? M_LEFT : M_RIGHT);
      S_IDLE: begin
        if (follow_en && near) begin
          if (ir_l && ir_r) nxt_mode = M_FWD;
          else if (ir_l)    nxt_mode = M_LEFT;
          else if (ir_r)    nxt_mode = M_RIGHT;
          else              nxt_mode = M_STOP;
        end
      end
      default: nxt_mode = M_STOP;
    endcase
  end

  assign mode  = mode_r;
  assign done  = done_r;
  assign busy  = busy_r;
  assign state = cur_state;

endmodule
`default_nettype wire
